mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port, synchronous-read 16-bit main memory (1024 words, 10-bit word address) between the `cpu` and a secondary bus master (boot loader / DMA port, here "dma"). Sits between the masters and the memory array. Grants one access per cycle and routes the one-cycle-latency read data back to the owner with a valid strobe. Fixed priority to the CPU, with a starvation counter that forces a DMA grant after a bounded wait.

---
 rtl/mem_pkg.sv | 8 +
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared widths and state encodings for the main-memory arbiter.
package mem_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {NONE, CPU, DMA} owner_t;
    typedef enum logic       {PRI_CPU, PRI_DMA} prio_t;
endpackage

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for the single-port synchronous-read main memory.
// Fixed CPU priority with a starvation counter that forces a DMA grant.
module mem_arbiter #(
    parameter int ADDR_W       = mem_pkg::ADDR_W,
    parameter int DATA_W       = mem_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data
);
    import mem_pkg::*;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_t            rd_owner, owner_nxt;
    prio_t             prio, prio_nxt;
    logic [3:0]        d_wait, wait_nxt;
    logic [ADDR_W-1:0] addr_q;

    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (prio == PRI_DMA && d_req) d_gnt = 1'b1;
        else if (c_req)               c_gnt = 1'b1;
        else if (d_req)               d_gnt = 1'b1;
    end

    // With no grant the address bus parks on the last driven value.
    always_comb begin
        mem_addr = addr_q;
        mem_wr   = 1'b0;
        wr_data  = c_wdata;
        if (c_gnt) begin
            mem_addr = c_addr;
            mem_wr   = c_wr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
            mem_wr   = d_wr;
            wr_data  = d_wdata;
        end
    end

    always_comb begin
        wait_nxt = d_wait;
        if (!d_req || d_gnt)  wait_nxt = 4'd0;
        else if (d_wait < LIMIT) wait_nxt = d_wait + 4'd1;
        prio_nxt = (wait_nxt == LIMIT) ? PRI_DMA : PRI_CPU;

        owner_nxt = NONE;
        if (c_gnt && !c_wr)      owner_nxt = CPU;
        else if (d_gnt && !d_wr) owner_nxt = DMA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_wait   <= 4'd0;
            prio     <= PRI_CPU;
            rd_owner <= NONE;
            addr_q   <= '0;
        end else begin
            d_wait   <= wait_nxt;
            prio     <= prio_nxt;
            rd_owner <= owner_nxt;
            addr_q   <= mem_addr;
        end
    end

    assign c_rvalid = (rd_owner == CPU);
    assign d_rvalid = (rd_owner == DMA);
    assign rdata    = rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read memory.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0, c_wr = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [9:0]  c_addr = '0, d_addr = '0, mem_addr;
    logic [15:0] c_wdata = '0, d_wdata = '0, rdata, wr_data;
    logic [15:0] rd_data = '0;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, mem_wr;
    logic [15:0] mem [0:1023];
    int          checks = 0;
    int          failures = 0;

    mem_arbiter #(.ADDR_W(10), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr),
        .wr_data(wr_data), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= wr_data;
        rd_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setin(input logic cr, input logic cw, input logic [9:0] ca, input logic [15:0] cd,
                         input logic dr, input logic dw, input logic [9:0] da, input logic [15:0] dd);
        c_req = cr; c_wr = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_wr = dw; d_addr = da; d_wdata = dd;
    endtask

    initial begin
        logic [9:0]  pa [3];
        logic [15:0] pd [3];
        pa[0] = 10'h100; pd[0] = 16'h1234;
        pa[1] = 10'h200; pd[1] = 16'hAAAA;
        pa[2] = 10'h300; pd[2] = 16'h5555;

        // reset state
        #12;
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;

        // preload through CPU writes
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) setin(1, 1, pa[i], pd[i], 0, 0, 0, 0);
            #1 chk("pre_c_gnt", c_gnt, 1);
            chk("pre_mem_wr", mem_wr, 1);
            chk("pre_wr_data", wr_data, pd[i]);
            @(posedge clk) #1 chk("pre_no_rvalid", c_rvalid, 0);
        end

        // single CPU read
        @(negedge clk) setin(1, 0, 10'h100, 0, 0, 0, 0, 0);
        #1 chk("rd_c_gnt", c_gnt, 1);
        chk("rd_d_gnt", d_gnt, 0);
        chk("rd_mem_addr", mem_addr, 10'h100);
        chk("rd_mem_wr", mem_wr, 0);
        @(posedge clk) #1 chk("rd_c_rvalid", c_rvalid, 1);
        chk("rd_d_rvalid", d_rvalid, 0);
        chk("rd_rdata", rdata, 16'h1234);
        @(negedge clk) setin(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("idle_mem_wr", mem_wr, 0);
        chk("idle_addr_hold", mem_addr, 10'h100);

        // starvation: DMA granted in cycles 5 and 10 with CPU continuous
        @(negedge clk) setin(1, 0, 10'h010, 0, 1, 0, 10'h020, 0);
        for (int k = 1; k <= 10; k++) begin
            #1 chk($sformatf("stv_c_gnt%0d", k), c_gnt, (k != 5 && k != 10));
            chk($sformatf("stv_d_gnt%0d", k), d_gnt, (k == 5 || k == 10));
            chk($sformatf("stv_addr%0d", k), mem_addr, (k == 5 || k == 10) ? 10'h020 : 10'h010);
            @(posedge clk) #1 chk($sformatf("stv_d_rvalid%0d", k), d_rvalid, (k == 5 || k == 10));
            @(negedge clk);
        end
        setin(0, 0, 0, 0, 0, 0, 0, 0);

        // DMA write then CPU read-back of the same word
        @(negedge clk) setin(0, 0, 0, 0, 1, 1, 10'h001, 16'hBEEF);
        #1 chk("dw_d_gnt", d_gnt, 1);
        chk("dw_mem_wr", mem_wr, 1);
        chk("dw_mem_addr", mem_addr, 10'h001);
        chk("dw_wr_data", wr_data, 16'hBEEF);
        @(posedge clk) #1 chk("dw_no_rvalid", d_rvalid, 0);
        @(negedge clk) setin(1, 0, 10'h001, 0, 0, 0, 0, 0);
        #1 chk("dw_rb_mem_wr", mem_wr, 0);
        chk("dw_rb_c_gnt", c_gnt, 1);
        @(posedge clk) #1 chk("dw_rb_c_rvalid", c_rvalid, 1);
        chk("dw_rb_rdata", rdata, 16'hBEEF);

        // alternating owners, back-to-back reads
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i % 2 == 0) setin(1, 0, 10'h200, 0, 0, 0, 0, 0);
            else            setin(0, 0, 0, 0, 1, 0, 10'h300, 0);
            @(posedge clk) #1 chk($sformatf("alt_c_rvalid%0d", i), c_rvalid, (i % 2 == 0));
            chk($sformatf("alt_d_rvalid%0d", i), d_rvalid, (i % 2 == 1));
            chk($sformatf("alt_rdata%0d", i), rdata, (i % 2 == 0) ? 16'hAAAA : 16'h5555);
        end
        @(negedge clk) setin(0, 0, 0, 0, 0, 0, 0, 0);

        // reset while a granted read is in flight
        @(negedge clk) setin(1, 0, 10'h100, 0, 0, 0, 0, 0);
        @(posedge clk) #2 setin(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1 chk("mrst_c_rvalid", c_rvalid, 0);
        chk("mrst_mem_addr", mem_addr, 0);
        chk("mrst_mem_wr", mem_wr, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1 chk("mrst_after_c_rvalid", c_rvalid, 0);

        // DMA abandons after 3 denials; counter must restart from zero
        @(negedge clk) setin(1, 0, 10'h010, 0, 1, 0, 10'h020, 0);
        for (int k = 1; k <= 3; k++) begin
            #1 chk($sformatf("abn_d_gnt%0d", k), d_gnt, 0);
            @(posedge clk);
            @(negedge clk);
        end
        d_req = 1'b0;
        #1 chk("abn_drop_c_gnt", c_gnt, 1);
        @(posedge clk);
        @(negedge clk) d_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1 chk($sformatf("abn_re_d_gnt%0d", k), d_gnt, (k == 5));
            @(posedge clk);
            @(negedge clk);
        end
        setin(0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
